spi_shift_engine: RTL

SPI bit engine downstream of the slow-clock edge detector. It consumes the detector's single-cycle rising and falling strobes derived from SCLK. It shifts DATA_WIDTH bits out on MOSI and samples MISO. It frames the transfer with chip-select and an SCLK-enable request to the clock generator, and returns the received word with a one-cycle valid pulse.

---
 rtl/spi_shift_engine.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI bit engine driven by single-cycle SCLK edge strobes.
// Shifts DATA_WIDTH bits out on MOSI, samples MISO, frames the transfer with
// chip-select and an SCLK-enable request, and returns the received word with
// a one-cycle valid pulse.
// Optional build macro: SPI_LSB_FIRST_EN (defined = LSB-first on MOSI and MISO;
// undefined = MSB-first). Timing, states and counts are the same in both builds.
`timescale 1ns/1ps

module spi_shift_engine #(
  parameter int DATA_WIDTH = 8,  // bits per transfer, >= 2
  parameter int CPHA       = 0   // 0: sample rising/shift falling, 1: shift rising/sample falling
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rising_edge,
  input  logic                  i_falling_edge,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_miso,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_sclk_en,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [DATA_WIDTH-1:0] tx_q,      tx_d;
  logic [DATA_WIDTH-1:0] rx_q,      rx_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  first_q,   first_d;    // CPHA=1: first rising edge not yet seen
  logic                  mosi_q,    mosi_d;
  logic                  cs_n_q,    cs_n_d;
  logic                  sclk_en_q, sclk_en_d;
  logic                  busy_q,    busy_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  // Bit-order dependent views of the shift registers.
  logic                  tx_first_bit;
  logic                  tx_next_bit;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic [DATA_WIDTH-1:0] rx_shifted;

`ifdef SPI_LSB_FIRST_EN
  // LSB-first: TX shifts right, RX fills from the MSB side downward.
  assign tx_first_bit = tx_q[0];
  assign tx_next_bit  = tx_q[1];
  assign tx_shifted   = {1'b0, tx_q[DATA_WIDTH-1:1]};
  assign rx_shifted   = {i_miso, rx_q[DATA_WIDTH-1:1]};
`else
  // MSB-first: TX shifts left, RX fills from the LSB side upward.
  assign tx_first_bit = tx_q[DATA_WIDTH-1];
  assign tx_next_bit  = tx_q[DATA_WIDTH-2];
  assign tx_shifted   = {tx_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_shifted   = {rx_q[DATA_WIDTH-2:0], i_miso};
`endif

  // Next-state logic: FSM sequencing, shifting and output framing.
  always_comb begin
    logic finish;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    sclk_en_d  = sclk_en_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    finish     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Edge strobes are ignored here; only a start request matters.
        if (i_start) begin
          state_d = ST_SETUP;
          tx_d    = i_tx_data;
          rx_d    = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_XFER;
        mosi_d    = tx_first_bit;
        cnt_d     = '0;
        sclk_en_d = 1'b1;
      end

      ST_XFER: begin
        // A rising strobe wins over a simultaneous falling strobe.
        if (CPHA == 0) begin
          if (i_rising_edge) begin
            rx_d  = rx_shifted;
            cnt_d = cnt_q + 1'b1;
          end else if (i_falling_edge) begin
            if (cnt_q == CNT_FULL) begin
              finish = 1'b1;
            end else begin
              tx_d   = tx_shifted;
              mosi_d = tx_next_bit;
            end
          end
        end else begin
          if (i_rising_edge) begin
            if (first_q) begin
              first_d = 1'b0;  // MSB/LSB already on the line from SETUP
            end else begin
              tx_d   = tx_shifted;
              mosi_d = tx_next_bit;
            end
          end else if (i_falling_edge) begin
            rx_d  = rx_shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              finish = 1'b1;
            end
          end
        end

        // Completing edge: outputs for the DONE cycle are registered now so
        // the valid pulse and deasserted chip-select appear one cycle later.
        if (finish) begin
          state_d    = ST_DONE;
          rx_data_d  = rx_d;
          rx_valid_d = 1'b1;
          sclk_en_d  = 1'b0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
        end
      end

      ST_DONE: begin
        // Start requests here are dropped; the next one is taken in IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      sclk_en_q  <= sclk_en_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign o_mosi     = mosi_q;
  assign o_cs_n     = cs_n_q;
  assign o_sclk_en  = sclk_en_q;
  assign o_busy     = busy_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;

endmodule
